gpio_debounce: RTL and testbench

GPIO_DEBOUNCE -- requirements
Module: gpio_debounce

---
 rtl/gpio_debounce_if.sv | 27 ++
 rtl/gpio_debounce.sv | 118 +++++++++++
 tb/tb_gpio_debounce.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_debounce_if.sv
// Bus port bundle for gpio_debounce.
//   mem_valid  request valid (master -> slave)
//   mem_addr   byte address
//   mem_wdata  write data
//   mem_wstrb  byte write strobes, all zero = read
//   dbn_ready  request done (slave -> master)
//   dbn_sel    slave decodes the current request
//   dbn_rdata  read data
interface gpio_debounce_if;
   logic        mem_valid;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        dbn_ready;
   logic        dbn_sel;
   logic [31:0] dbn_rdata;

   modport master (
      output mem_valid, mem_addr, mem_wdata, mem_wstrb,
      input  dbn_ready, dbn_sel, dbn_rdata
   );

   modport slave (
      input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
      output dbn_ready, dbn_sel, dbn_rdata
   );
endinterface

// File: rtl/gpio_debounce.sv
// 8-pin input debouncer with edge-status registers and a level interrupt.
//   clk         single clock, rising edge
//   resetn      asynchronous active-low reset
//   bus         register bus (slave side): STATE @ADDR, EDGE @ADDR+4 (W1C),
//               MASK @ADDR+8
//   pin_raw     asynchronous external pins
//   pin_stable  debounced pin state
//   edge_irq    |(EDGE & MASK), combinational from registered state
//
// Every pin is double-synchronized, then a per-pin counter must see
// DEBOUNCE_CYCLES consecutive mismatching samples before the new level is
// accepted. A held change therefore shows up DEBOUNCE_CYCLES+2 edges after
// the first sampling edge (two synchronizer stages plus the count).
module gpio_debounce #(
   parameter logic [31:0] ADDR            = 32'hffff_ffff,
   parameter int          DEBOUNCE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              resetn,
   gpio_debounce_if.slave    bus,
   input  logic [7:0]        pin_raw,
   output logic [7:0]        pin_stable,
   output logic              edge_irq
);

   localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
   // Register offsets wrap modulo 2^32, matching the bus address width.
   localparam logic [31:0]     A_STATE = ADDR;
   localparam logic [31:0]     A_EDGE  = ADDR + 32'd4;
   localparam logic [31:0]     A_MASK  = ADDR + 32'd8;

   logic [7:0]    r_sync1;
   logic [7:0]    r_sync2;
   logic [7:0]    r_stable;
   logic [CW-1:0] r_cnt [8];
   logic [7:0]    r_edge;
   logic [7:0]    r_mask;

   logic          w_hit_state;
   logic          w_hit_edge;
   logic          w_hit_mask;
   logic          w_we;
   logic [7:0]    w_commit;
   logic [7:0]    w_edge_clr;
   logic          w_unused_bits;

   // ---------------- bus decode ----------------
   assign w_hit_state   = (bus.mem_addr == A_STATE);
   assign w_hit_edge    = (bus.mem_addr == A_EDGE);
   assign w_hit_mask    = (bus.mem_addr == A_MASK);

   assign bus.dbn_sel   = bus.mem_valid & (w_hit_state | w_hit_edge | w_hit_mask);
   assign bus.dbn_ready = 1'b1;

   // Only the low byte lane carries register bits.
   assign w_we          = bus.dbn_sel & bus.mem_wstrb[0];
   assign w_edge_clr    = (w_we && w_hit_edge) ? bus.mem_wdata[7:0] : 8'h00;
   assign w_unused_bits = ^{bus.mem_wdata[31:8], bus.mem_wstrb[3:1]};

   always_comb begin
      bus.dbn_rdata = 32'h0;
      if (bus.dbn_sel) begin
         if (w_hit_state)     bus.dbn_rdata = {24'h0, r_stable};
         else if (w_hit_edge) bus.dbn_rdata = {24'h0, r_edge};
         else                 bus.dbn_rdata = {24'h0, r_mask};
      end
   end

   // ---------------- debounce ----------------
   // A pin commits when it still disagrees with stable and its counter
   // already holds the terminal value; counter cannot pass CNT_MAX.
   always_comb begin
      w_commit = 8'h00;
      for (int i = 0; i < 8; i++) begin
         w_commit[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == CNT_MAX);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sync1 <= 8'h00;
         r_sync2 <= 8'h00;
      end else begin
         r_sync1 <= pin_raw;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < 8; i++) r_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (r_sync2[i] == r_stable[i])  r_cnt[i] <= '0;
            else if (r_cnt[i] == CNT_MAX)   r_cnt[i] <= '0;
            else                            r_cnt[i] <= r_cnt[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_stable <= 8'h00;
         r_edge   <= 8'h00;
         r_mask   <= 8'h00;
      end else begin
         r_stable <= r_stable ^ w_commit;
         // Set beats a simultaneous W1C clear.
         r_edge   <= (r_edge & ~w_edge_clr) | w_commit;
         if (w_we && w_hit_mask) r_mask <= bus.mem_wdata[7:0];
      end
   end

   assign pin_stable = r_stable;
   assign edge_irq   = |(r_edge & r_mask);

endmodule

// File: tb/tb_gpio_debounce.sv
module tb_gpio_debounce;
   localparam logic [31:0] BASE = 32'h1000_0100;
   localparam logic [31:0] A_ST = BASE;
   localparam logic [31:0] A_ED = BASE + 32'd4;
   localparam logic [31:0] A_MK = BASE + 32'd8;

   logic       clk = 1'b0;
   logic       resetn;
   logic [7:0] pin_raw;
   logic [7:0] pin_stable;
   logic       edge_irq;

   int n_checks = 0;
   int n_pass   = 0;

   gpio_debounce_if bus ();

   gpio_debounce #(.ADDR(BASE), .DEBOUNCE_CYCLES(16)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .bus        (bus.slave),
      .pin_raw    (pin_raw),
      .pin_stable (pin_stable),
      .edge_irq   (edge_irq)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        exp_sel;
      logic [31:0] exp_rdata;
      logic        exp_irq;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic bus_idle();
      bus.mem_valid = 1'b0;
      bus.mem_addr  = 32'h0;
      bus.mem_wdata = 32'h0;
      bus.mem_wstrb = 4'h0;
   endtask

   // Advance one rising edge; return 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] data);
      bus.mem_valid = 1'b1;
      bus.mem_addr  = addr;
      bus.mem_wstrb = 4'h0;
      #1;
      data = bus.dbn_rdata;
      bus_idle();
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      bus.mem_valid = 1'b1;
      bus.mem_addr  = addr;
      bus.mem_wdata = data;
      bus.mem_wstrb = strb;
      step();
      bus_idle();
   endtask

   initial begin
      logic [31:0] d;

      // state on entry to the table: stable=01, EDGE=01, MASK=00
      vecs[0]  = '{1'b1, A_ST,          32'h0,  4'h0, 1'b1, 32'h1, 1'b0};
      vecs[1]  = '{1'b1, A_ED,          32'h0,  4'h0, 1'b1, 32'h1, 1'b0};
      vecs[2]  = '{1'b1, A_MK,          32'h0,  4'h0, 1'b1, 32'h0, 1'b0};
      vecs[3]  = '{1'b1, BASE + 32'd12, 32'h0,  4'h0, 1'b0, 32'h0, 1'b0};
      vecs[4]  = '{1'b1, BASE + 32'd1,  32'h0,  4'h0, 1'b0, 32'h0, 1'b0};
      vecs[5]  = '{1'b1, A_MK,          32'h1,  4'h2, 1'b1, 32'h0, 1'b0};
      vecs[6]  = '{1'b1, A_MK,          32'h0,  4'h0, 1'b1, 32'h0, 1'b0};
      vecs[7]  = '{1'b1, A_ST,          32'hff, 4'h1, 1'b1, 32'h1, 1'b0};
      vecs[8]  = '{1'b1, A_ST,          32'h0,  4'h0, 1'b1, 32'h1, 1'b0};
      vecs[9]  = '{1'b0, BASE + 32'd12, 32'hff, 4'hf, 1'b0, 32'h0, 1'b0};
      vecs[10] = '{1'b1, A_MK,          32'h1,  4'h1, 1'b1, 32'h0, 1'b0};
      vecs[11] = '{1'b1, A_MK,          32'h0,  4'h0, 1'b1, 32'h1, 1'b1};
      vecs[12] = '{1'b1, A_ED,          32'h0,  4'hf, 1'b1, 32'h1, 1'b1};
      vecs[13] = '{1'b1, A_ED,          32'h1,  4'he, 1'b1, 32'h1, 1'b1};
      vecs[14] = '{1'b1, A_ED,          32'h1,  4'h1, 1'b1, 32'h1, 1'b1};
      vecs[15] = '{1'b1, A_ED,          32'h0,  4'h0, 1'b1, 32'h0, 1'b0};

      bus_idle();
      pin_raw = 8'h00;
      resetn  = 1'b0;
      #23;
      check("rst_pin_stable", {24'h0, pin_stable}, 32'h0);
      check("rst_irq", {31'h0, edge_irq}, 32'h0);
      check("rst_ready", {31'h0, bus.dbn_ready}, 32'h1);
      step();
      resetn = 1'b1;
      repeat (4) step();

      // pin 0 rises: visible exactly on the 18th edge
      pin_raw[0] = 1'b1;
      repeat (17) step();
      check("rise_edge17", {24'h0, pin_stable}, 32'h0);
      step();
      check("rise_edge18", {24'h0, pin_stable}, 32'h1);
      rd(A_ED, d);
      check("rise_edge_reg", d, 32'h1);
      check("rise_irq_masked", {31'h0, edge_irq}, 32'h0);

      // register access table
      for (int i = 0; i < 16; i++) begin
         bus.mem_valid = vecs[i].valid;
         bus.mem_addr  = vecs[i].addr;
         bus.mem_wdata = vecs[i].wdata;
         bus.mem_wstrb = vecs[i].wstrb;
         #1;
         check($sformatf("vec%0d_sel", i), {31'h0, bus.dbn_sel}, {31'h0, vecs[i].exp_sel});
         check($sformatf("vec%0d_rdata", i), bus.dbn_rdata, vecs[i].exp_rdata);
         check($sformatf("vec%0d_irq", i), {31'h0, edge_irq}, {31'h0, vecs[i].exp_irq});
         step();
         bus_idle();
      end

      // 10-cycle glitch on pin 1 (MASK=01): nothing changes, counter idles
      pin_raw[1] = 1'b1;
      repeat (10) step();
      pin_raw[1] = 1'b0;
      repeat (5) step();
      check("glitch10_cnt", {28'h0, dut.r_cnt[1]}, 32'h0);
      check("glitch10_stable", {24'h0, pin_stable}, 32'h1);
      rd(A_ED, d);
      check("glitch10_edge", d, 32'h0);
      check("glitch10_irq", {31'h0, edge_irq}, 32'h0);

      // 15-cycle pulse is one short of committing
      pin_raw[1] = 1'b1;
      repeat (15) step();
      pin_raw[1] = 1'b0;
      repeat (20) step();
      check("glitch15_stable", {24'h0, pin_stable}, 32'h1);
      rd(A_ED, d);
      check("glitch15_edge", d, 32'h0);

      // 16-cycle pulse commits high then low; EDGE[1] latched
      pin_raw[1] = 1'b1;
      repeat (16) step();
      pin_raw[1] = 1'b0;
      repeat (40) step();
      check("pulse16_stable", {24'h0, pin_stable}, 32'h1);
      rd(A_ED, d);
      check("pulse16_edge", d, 32'h2);
      wr(A_ED, 32'h2, 4'h1);
      rd(A_ED, d);
      check("pulse16_clear", d, 32'h0);

      // pin 3 falls with MASK=FF
      wr(A_MK, 32'hff, 4'h1);
      pin_raw[3] = 1'b1;
      repeat (20) step();
      wr(A_ED, 32'hff, 4'h1);
      rd(A_ED, d);
      check("fall_pre_edge", d, 32'h0);
      check("fall_pre_irq", {31'h0, edge_irq}, 32'h0);
      pin_raw[3] = 1'b0;
      repeat (18) step();
      check("fall_stable", {24'h0, pin_stable}, 32'h1);
      rd(A_ED, d);
      check("fall_edge", d, 32'h8);
      check("fall_irq", {31'h0, edge_irq}, 32'h1);
      wr(A_ED, 32'h8, 4'h1);
      rd(A_ED, d);
      check("fall_w1c_edge", d, 32'h0);
      check("fall_w1c_irq", {31'h0, edge_irq}, 32'h0);

      // W1C of bit 2 on the very edge where stable[2] rises: set wins
      pin_raw[2] = 1'b1;
      repeat (17) step();
      check("race_pre_stable", {24'h0, pin_stable}, 32'h1);
      wr(A_ED, 32'h4, 4'h1);
      check("race_stable", {24'h0, pin_stable}, 32'h5);
      rd(A_ED, d);
      check("race_edge", d, 32'h4);
      check("race_irq", {31'h0, edge_irq}, 32'h1);

      // async reset mid-count on pin 4
      pin_raw[4] = 1'b1;
      repeat (8) step();
      #2 resetn = 1'b0;
      #1;
      check("arst_stable", {24'h0, pin_stable}, 32'h0);
      check("arst_irq", {31'h0, edge_irq}, 32'h0);
      rd(A_ED, d);
      check("arst_edge", d, 32'h0);
      rd(A_MK, d);
      check("arst_mask", d, 32'h0);
      step();
      check("arst_cnt4", {28'h0, dut.r_cnt[4]}, 32'h0);
      resetn = 1'b1;
      repeat (17) step();
      check("rel_edge17", {24'h0, pin_stable}, 32'h0);
      step();
      check("rel_edge18", {24'h0, pin_stable}, 32'h15);
      rd(A_ED, d);
      check("rel_edge_reg", d, 32'h15);
      check("rel_irq", {31'h0, edge_irq}, 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
